// File: rtl/usb_rx_status_mlane.sv
// Multi-lane PIPE RxValid/RxStatus generator: per-lane disparity tracking, comma lock FSM and
// elastic-buffer event merge. Define RX_STATUS_ERRCNT_EN to add the saturating err_cnt_o port.
module usb_rx_status_mlane #(
    parameter int unsigned LANES       = 1,
    parameter int unsigned LOCK_COMMAS = 4,
    parameter int unsigned ERR_LIMIT   = 8,
    parameter int unsigned CNT_W       = 16,
    parameter logic [9:0]  COM_NEG     = 10'b0011111010,
    parameter logic [9:0]  COM_POS     = 10'b1100000101
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [LANES-1:0]       sym_valid_i,
    input  logic [10*LANES-1:0]    sym_data_i,
    input  logic [LANES-1:0]       buf_skp_add_i,
    input  logic [LANES-1:0]       buf_skp_rem_i,
    input  logic [LANES-1:0]       buf_full_i,
    input  logic [LANES-1:0]       buf_empty_i,
    output logic [LANES-1:0]       rx_valid_o,
    output logic [3*LANES-1:0]     rx_status_o
`ifdef RX_STATUS_ERRCNT_EN
    ,
    output logic [CNT_W*LANES-1:0] err_cnt_o
`endif
);

    localparam int unsigned ComW = $clog2(LOCK_COMMAS + 1);
    localparam int unsigned ErrW = $clog2(ERR_LIMIT + 1);
    localparam logic [ComW-1:0] LockCommasW = ComW'(LOCK_COMMAS);
    localparam logic [ErrW-1:0] ErrLimitW   = ErrW'(ERR_LIMIT);

    typedef enum logic [1:0] {StUnlocked, StAlign, StLocked} lock_state_e;

    function automatic logic [3:0] popcount10(input logic [9:0] s);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 10; i++) begin
            c = c + {3'b000, s[i]};
        end
        return c;
    endfunction

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [9:0]      sym;
        logic            vld;
        logic [3:0]      ones;
        logic            code_err;
        logic            disp_err;
        logic            is_com;
        lock_state_e     state_q, state_d;
        logic [ComW-1:0] com_cnt_q, com_cnt_d;
        logic [ErrW-1:0] err_run_q, err_run_d;
        logic            rd_q, rd_d;      // 1 = positive running disparity
        logic [2:0]      status_q, status_d;
        logic            valid_q;

        assign sym      = sym_data_i[10*n +: 10];
        assign vld      = sym_valid_i[n];
        assign ones     = popcount10(sym);
        assign code_err = vld && ((ones < 4'd4) || (ones > 4'd6));
        assign disp_err = vld && !code_err &&
                          (((ones == 4'd6) && rd_q) || ((ones == 4'd4) && !rd_q));
        assign is_com   = vld && ((sym == COM_NEG) || (sym == COM_POS));

        // A received COM re-anchors RD to the disparity that follows it.
        always_comb begin
            rd_d = rd_q;
            if (vld && !code_err && !disp_err) begin
                if (ones == 4'd6) begin
                    rd_d = 1'b1;
                end else if (ones == 4'd4) begin
                    rd_d = 1'b0;
                end
            end
            if (is_com) begin
                rd_d = (sym == COM_NEG);
            end
        end

        always_comb begin
            state_d   = state_q;
            com_cnt_d = com_cnt_q;
            err_run_d = err_run_q;
            if (vld) begin
                unique case (state_q)
                    StUnlocked: begin
                        if (is_com) begin
                            com_cnt_d = ComW'(1);
                            state_d   = (ComW'(1) >= LockCommasW) ? StLocked : StAlign;
                        end
                    end
                    StAlign: begin
                        if (is_com) begin
                            com_cnt_d = com_cnt_q + ComW'(1);
                            if (com_cnt_d >= LockCommasW) begin
                                state_d = StLocked;
                            end
                        end else begin
                            com_cnt_d = '0;
                            state_d   = StUnlocked;
                        end
                    end
                    StLocked: begin
                        if (code_err || disp_err) begin
                            err_run_d = err_run_q + ErrW'(1);
                            if (err_run_d >= ErrLimitW) begin
                                err_run_d = '0;
                                state_d   = StUnlocked;
                            end
                        end else begin
                            err_run_d = '0;
                        end
                    end
                    default: state_d = StUnlocked;
                endcase
            end
        end

        always_comb begin
            status_d = 3'b000;
            if (code_err) begin
                status_d = 3'b100;
            end else if (buf_full_i[n]) begin
                status_d = 3'b101;
            end else if (buf_empty_i[n]) begin
                status_d = 3'b110;
            end else if (disp_err) begin
                status_d = 3'b111;
            end else if (buf_skp_add_i[n]) begin
                status_d = 3'b001;
            end else if (buf_skp_rem_i[n]) begin
                status_d = 3'b010;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q   <= StUnlocked;
                com_cnt_q <= '0;
                err_run_q <= '0;
                rd_q      <= 1'b0;
                status_q  <= 3'b000;
                valid_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                com_cnt_q <= com_cnt_d;
                err_run_q <= err_run_d;
                rd_q      <= rd_d;
                status_q  <= status_d;
                valid_q   <= (state_d == StLocked);
            end
        end

        assign rx_valid_o[n]          = valid_q;
        assign rx_status_o[3*n +: 3]  = status_q;

`ifdef RX_STATUS_ERRCNT_EN
        logic [CNT_W-1:0] err_cnt_q;

        // Counts alongside the status register so err_cnt_o tracks rx_status_o cycle for cycle.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                err_cnt_q <= '0;
            end else if (((status_d == 3'b100) || (status_d == 3'b111)) && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end

        assign err_cnt_o[CNT_W*n +: CNT_W] = err_cnt_q;
`endif
    end

endmodule

// File: tb/tb_usb_rx_status_mlane.sv
// Directed bench for usb_rx_status_mlane with two lanes; err_cnt checks need RX_STATUS_ERRCNT_EN.
module tb_usb_rx_status_mlane;

    localparam logic [9:0] CN   = 10'b0011111010;
    localparam logic [9:0] CP   = 10'b1100000101;
    localparam logic [9:0] BAD7 = 10'b1111111000;
    localparam logic [9:0] D4   = 10'b0000001111;
    localparam logic [9:0] D5   = 10'b0000011111;

    logic        clk;
    logic        rst;
    logic [1:0]  sym_valid;
    logic [19:0] sym_data;
    logic [1:0]  skp_add;
    logic [1:0]  skp_rem;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic [1:0]  rx_valid;
    logic [5:0]  rx_status;
`ifdef RX_STATUS_ERRCNT_EN
    logic [3:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    usb_rx_status_mlane #(
        .LANES(2),
        .LOCK_COMMAS(4),
        .ERR_LIMIT(8),
        .CNT_W(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .sym_valid_i(sym_valid),
        .sym_data_i(sym_data),
        .buf_skp_add_i(skp_add),
        .buf_skp_rem_i(skp_rem),
        .buf_full_i(full),
        .buf_empty_i(empty),
        .rx_valid_o(rx_valid),
        .rx_status_o(rx_status)
`ifdef RX_STATUS_ERRCNT_EN
        ,
        .err_cnt_o(err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int ln, input logic v, input logic [9:0] d);
        sym_valid[ln] = v;
        sym_data[10*ln +: 10] = d;
    endtask

    task automatic send0(input logic [9:0] d);
        set_lane(0, 1'b1, d);
        tick();
        set_lane(0, 1'b0, 10'd0);
    endtask

    task automatic send1(input logic [9:0] d);
        set_lane(1, 1'b1, d);
        tick();
        set_lane(1, 1'b0, 10'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sym_valid = '0; sym_data = '0;
        skp_add = '0; skp_rem = '0; full = '0; empty = '0;
        tick();
        tick();
        checks++;
        if (rx_valid !== 2'b00) begin
            errors++; $display("FAIL reset_valid: got %b expected %b", rx_valid, 2'b00);
        end
        checks++;
        if (rx_status !== 6'b000000) begin
            errors++; $display("FAIL reset_status: got %b expected %b", rx_status, 6'b000000);
        end
`ifdef RX_STATUS_ERRCNT_EN
        checks++;
        if (err_cnt !== 4'b0000) begin
            errors++; $display("FAIL reset_errcnt: got %b expected %b", err_cnt, 4'b0000);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_lock();
        send0(CN);
        send0(CP);
        send0(CN);
        checks++;
        if (rx_valid !== 2'b00) begin
            errors++; $display("FAIL lock_early: got %b expected %b", rx_valid, 2'b00);
        end
        send0(CP);
        checks++;
        if (rx_valid !== 2'b01) begin
            errors++; $display("FAIL lock_valid: got %b expected %b", rx_valid, 2'b01);
        end
        checks++;
        if (rx_status !== 6'b000000) begin
            errors++; $display("FAIL lock_status: got %b expected %b", rx_status, 6'b000000);
        end
        tick();
        checks++;
        if (rx_valid !== 2'b01 || rx_status !== 6'b000000) begin
            errors++;
            $display("FAIL lock_hold: got %b/%b expected 01/000000", rx_valid, rx_status);
        end
    endtask

    task automatic test_code_err();
        send0(BAD7);
        checks++;
        if (rx_status !== 6'b000100) begin
            errors++; $display("FAIL code_err_status: got %b expected %b", rx_status, 6'b000100);
        end
        // RD still negative, so a 4-ones symbol is a disparity error.
        send0(D4);
        checks++;
        if (rx_status !== 6'b000111) begin
            errors++; $display("FAIL rd_unchanged: got %b expected %b", rx_status, 6'b000111);
        end
        repeat (5) send0(BAD7);
        checks++;
        if (rx_valid !== 2'b01) begin
            errors++; $display("FAIL no_unlock_at_7: got %b expected %b", rx_valid, 2'b01);
        end
        send0(BAD7);
        checks++;
        if (rx_valid !== 2'b00 || rx_status !== 6'b000100) begin
            errors++;
            $display("FAIL unlock_at_8: got %b/%b expected 00/000100", rx_valid, rx_status);
        end
    endtask

    task automatic test_disparity();
        send0(CN); send0(CP); send0(CN); send0(CP);
        checks++;
        if (rx_valid !== 2'b01) begin
            errors++; $display("FAIL relock: got %b expected %b", rx_valid, 2'b01);
        end
        send0(CN);
        send0(D4);
        checks++;
        if (rx_status !== 6'b000000) begin
            errors++; $display("FAIL first_ones4: got %b expected %b", rx_status, 6'b000000);
        end
        send0(D4);
        checks++;
        if (rx_status !== 6'b000111) begin
            errors++; $display("FAIL second_ones4: got %b expected %b", rx_status, 6'b000111);
        end
        repeat (6) send0(D4);
        checks++;
        if (rx_valid !== 2'b01) begin
            errors++; $display("FAIL disp_seven: got %b expected %b", rx_valid, 2'b01);
        end
        send0(D5);
        checks++;
        if (rx_status !== 6'b000000) begin
            errors++; $display("FAIL clean_sym: got %b expected %b", rx_status, 6'b000000);
        end
        repeat (7) send0(D4);
        checks++;
        if (rx_valid !== 2'b01) begin
            errors++; $display("FAIL disp_run_cleared: got %b expected %b", rx_valid, 2'b01);
        end
        send0(D5);
    endtask

    task automatic test_priority();
        logic [2:0] exp_tab [9];
        exp_tab = '{3'b100, 3'b101, 3'b110, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111, 3'b000};
        for (int i = 0; i < 9; i++) begin
            sym_valid = '0; sym_data = '0;
            skp_add = '0; skp_rem = '0; full = '0; empty = '0;
            case (i)
                0: begin set_lane(0, 1'b1, BAD7); full[0] = 1'b1; skp_add[0] = 1'b1; end
                1: full[0] = 1'b1;
                2: empty[0] = 1'b1;
                3: begin skp_add[0] = 1'b1; skp_rem[0] = 1'b1; end
                4: skp_rem[0] = 1'b1;
                5: begin full[0] = 1'b1; empty[0] = 1'b1; end
                6: begin set_lane(0, 1'b1, D4); empty[0] = 1'b1; end
                7: begin set_lane(0, 1'b1, D4); skp_add[0] = 1'b1; end
                default: set_lane(0, 1'b0, BAD7);
            endcase
            tick();
            checks++;
            if (rx_status !== {3'b000, exp_tab[i]}) begin
                errors++;
                $display("FAIL priority_%0d: got %b expected %b", i, rx_status,
                         {3'b000, exp_tab[i]});
            end
        end
        sym_valid = '0; sym_data = '0;
        skp_add = '0; skp_rem = '0; full = '0; empty = '0;
        send0(D5);
        checks++;
        if (rx_valid !== 2'b01) begin
            errors++; $display("FAIL priority_lock: got %b expected %b", rx_valid, 2'b01);
        end
    endtask

    task automatic test_lanes();
        send1(BAD7);
        checks++;
        if (rx_valid !== 2'b01 || rx_status !== 6'b100000) begin
            errors++;
            $display("FAIL lane_indep: got %b/%b expected 01/100000", rx_valid, rx_status);
        end
        send1(CN); send1(CP); send1(CN);
        send1(D5);
        send1(CP); send1(CN); send1(CP);
        checks++;
        if (rx_valid !== 2'b01) begin
            errors++; $display("FAIL align_restart: got %b expected %b", rx_valid, 2'b01);
        end
        send1(CN);
        checks++;
        if (rx_valid !== 2'b11 || rx_status !== 6'b000000) begin
            errors++;
            $display("FAIL lane1_lock: got %b/%b expected 11/000000", rx_valid, rx_status);
        end
    endtask

    task automatic test_midreset();
`ifdef RX_STATUS_ERRCNT_EN
        checks++;
        if (err_cnt !== 4'b0111) begin
            errors++; $display("FAIL errcnt_pre_reset: got %b expected %b", err_cnt, 4'b0111);
        end
`endif
        rst = 1'b1;
        set_lane(0, 1'b1, BAD7);
        tick();
        rst = 1'b0;
        set_lane(0, 1'b0, 10'd0);
        checks++;
        if (rx_valid !== 2'b00 || rx_status !== 6'b000000) begin
            errors++;
            $display("FAIL midreset: got %b/%b expected 00/000000", rx_valid, rx_status);
        end
`ifdef RX_STATUS_ERRCNT_EN
        checks++;
        if (err_cnt !== 4'b0000) begin
            errors++; $display("FAIL midreset_errcnt: got %b expected %b", err_cnt, 4'b0000);
        end
`endif
        // RD back to negative: a 4-ones symbol must flag disparity.
        send0(D4);
        checks++;
        if (rx_valid !== 2'b00 || rx_status !== 6'b000111) begin
            errors++;
            $display("FAIL reset_rd: got %b/%b expected 00/000111", rx_valid, rx_status);
        end
        send0(BAD7);
`ifdef RX_STATUS_ERRCNT_EN
        checks++;
        if (err_cnt !== 4'b0010) begin
            errors++; $display("FAIL errcnt_two: got %b expected %b", err_cnt, 4'b0010);
        end
`endif
        repeat (3) send0(BAD7);
        checks++;
        if (rx_status !== 6'b000100) begin
            errors++; $display("FAIL post_reset_code: got %b expected %b", rx_status, 6'b000100);
        end
`ifdef RX_STATUS_ERRCNT_EN
        checks++;
        if (err_cnt !== 4'b0011) begin
            errors++; $display("FAIL errcnt_sat: got %b expected %b", err_cnt, 4'b0011);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_code_err();
        test_disparity();
        test_priority();
        test_lanes();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
